// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults, stage-count helper and parameter check for the adder family
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

package adder_pkg;

    localparam int ADDER_DEF_WIDTH = 16;
    localparam int ADDER_DEF_BLOCK = 4;

    // Number of skip blocks, which is also the pipeline depth; clamped to 1 so
    // a bad BLOCK still elaborates far enough to hit the parameter check.
    function automatic int adder_nblk(input int width, input int block);
        if (block < 1 || width < block) begin
            return 1;
        end
        return width / block;
    endfunction

// Elaboration-time guard: WIDTH must be a positive multiple of BLOCK.
`define ADDER_PARAM_CHECK(W, B) \
    if (((B) < 1) ? 1'b1 : (((W) % (B)) != 0)) begin : g_param_error \
        $fatal(1, "adder: WIDTH must be a positive multiple of BLOCK"); \
    end

endpackage

`endif

// File: rtl/skip_block.sv
// rtl/skip_block.sv - one carry-skip block: ripple chain plus block-propagate skip mux
module skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_prop
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;

    assign w_p = i_a ^ i_b;

    // ripple carry chain through the block
    always_comb begin
        w_c[0] = i_cin;
        for (int i = 0; i < BLOCK; i++) begin
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_p[i] & w_c[i]);
        end
    end

    assign o_sum  = w_p ^ w_c[BLOCK-1:0];
    assign o_prop = &w_p;
    // skip mux: when every bit propagates, the incoming carry bypasses the ripple chain
    assign o_cout = o_prop ? i_cin : w_c[BLOCK];

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// rtl/pipelined_carry_skip_adder.sv - elastic pipelined carry-skip adder/subtractor, one stage per skip block
module pipelined_carry_skip_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEF_WIDTH,
    parameter int BLOCK = ADDER_DEF_BLOCK
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NBLK = adder_nblk(WIDTH, BLOCK);

    `ADDER_PARAM_CHECK(WIDTH, BLOCK)

    logic [NBLK:0]    w_adv;
    logic [NBLK-1:0]  w_valid;
    logic [WIDTH-1:0] w_sum_q [NBLK];
    logic [WIDTH-1:0] w_a_q   [NBLK];
    logic [WIDTH-1:0] w_b_q   [NBLK];
    logic [NBLK-1:0]  w_c_q;

    // combinational ready chain: a stage moves when empty or when its successor moves
    always_comb begin
        w_adv[NBLK] = i_out_ready;
        for (int k = NBLK - 1; k >= 0; k--) begin
            w_adv[k] = !w_valid[k] || w_adv[k+1];
        end
    end

    assign o_in_ready = w_adv[0];

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum_nx;
        logic             w_c_in;
        logic             w_src_valid;
        logic             w_load;
        logic [BLOCK-1:0] w_blk_sum;
        logic             w_blk_cout;
        logic             w_blk_prop;

        if (k == 0) begin : g_src
            // subtract folds into an add of ~B with a forced carry-in
            assign w_a_in      = i_a;
            assign w_b_in      = i_sub ? ~i_b : i_b;
            assign w_c_in      = i_sub | i_cin;
            assign w_sum_in    = '0;
            assign w_src_valid = i_in_valid;
        end else begin : g_src
            assign w_a_in      = w_a_q[k-1];
            assign w_b_in      = w_b_q[k-1];
            assign w_c_in      = w_c_q[k-1];
            assign w_sum_in    = w_sum_q[k-1];
            assign w_src_valid = w_valid[k-1];
        end

        skip_block #(.BLOCK(BLOCK)) u_blk (
            .i_a    (w_a_in[k*BLOCK +: BLOCK]),
            .i_b    (w_b_in[k*BLOCK +: BLOCK]),
            .i_cin  (w_c_in),
            .o_sum  (w_blk_sum),
            .o_cout (w_blk_cout),
            .o_prop (w_blk_prop)
        );

        // splice this block's sum bits into the running partial sum
        always_comb begin
            w_sum_nx                   = w_sum_in;
            w_sum_nx[k*BLOCK +: BLOCK] = w_blk_sum;
        end

        assign w_load = w_adv[k] && w_src_valid;

        if (k == NBLK - 1) begin : g_reg
            logic             r_valid;
            logic [WIDTH-1:0] r_sum;
            logic             r_cout;
            logic             r_cmsb;

            // output stage: valid and visible result clear on reset so nothing stale is shown
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid <= 1'b0;
                    r_sum   <= '0;
                    r_cout  <= 1'b0;
                    r_cmsb  <= 1'b0;
                end else begin
                    if (w_adv[k]) begin
                        r_valid <= w_src_valid;
                    end
                    if (w_load) begin
                        r_sum  <= w_sum_nx;
                        r_cout <= w_blk_cout;
                        r_cmsb <= w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1] ^ w_blk_sum[BLOCK-1];
                    end
                end
            end

            assign w_valid[k] = r_valid;
            assign w_sum_q[k] = r_sum;
            assign w_a_q[k]   = '0;
            assign w_b_q[k]   = '0;
            assign w_c_q[k]   = r_cout;

            assign o_out_valid = r_valid;
            assign o_sum       = r_sum;
            assign o_cout      = r_cout;
            assign o_ovf       = r_cmsb ^ r_cout;
        end else begin : g_reg
            logic             r_valid;
            logic [WIDTH-1:0] r_sum;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic             r_c;

            // stage occupancy
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid <= 1'b0;
                end else if (w_adv[k]) begin
                    r_valid <= w_src_valid;
                end
            end

            // payload captured only when a real operation moves in
            always_ff @(posedge i_clk) begin
                if (w_load) begin
                    r_sum <= w_sum_nx;
                    r_a   <= w_a_in;
                    r_b   <= w_b_in;
                    r_c   <= w_blk_cout;
                end
            end

            assign w_valid[k] = r_valid;
            assign w_sum_q[k] = r_sum;
            assign w_a_q[k]   = r_a;
            assign w_b_q[k]   = r_b;
            assign w_c_q[k]   = r_c;
        end
    end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// tb/tb_pipelined_carry_skip_adder.sv - directed and randomized checks of the pipelined carry-skip adder
module tb_pipelined_carry_skip_adder;

    localparam int NI   = 3;
    localparam int WD [NI] = '{16, 8, 32};
    localparam int NB [NI] = '{4, 1, 8};
    localparam int NOPS = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid  [NI];
    logic        out_ready [NI];
    logic [31:0] a         [NI];
    logic [31:0] b         [NI];
    logic        cin       [NI];
    logic        sub       [NI];

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        co0, co1, co2;
    logic        of0, of1, of2;
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [31:0] s2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] sb     [NI][16];
    int          head   [NI];
    int          tail   [NI];
    int          infl   [NI];
    int          acc    [NI];
    int          popped [NI];
    logic        held_v [NI];
    logic [33:0] held   [NI];
    logic        saw_full;

    pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[0]), .o_in_ready(rdy0),
        .i_a(a[0][15:0]), .i_b(b[0][15:0]), .i_cin(cin[0]), .i_sub(sub[0]),
        .o_out_valid(ov0), .i_out_ready(out_ready[0]), .o_sum(s0), .o_cout(co0), .o_ovf(of0)
    );

    pipelined_carry_skip_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[1]), .o_in_ready(rdy1),
        .i_a(a[1][7:0]), .i_b(b[1][7:0]), .i_cin(cin[1]), .i_sub(sub[1]),
        .o_out_valid(ov1), .i_out_ready(out_ready[1]), .o_sum(s1), .o_cout(co1), .o_ovf(of1)
    );

    pipelined_carry_skip_adder #(.WIDTH(32), .BLOCK(4)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[2]), .o_in_ready(rdy2),
        .i_a(a[2]), .i_b(b[2]), .i_cin(cin[2]), .i_sub(sub[2]),
        .o_out_valid(ov2), .i_out_ready(out_ready[2]), .o_sum(s2), .o_cout(co2), .o_ovf(of2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int i);
        case (i)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic vld_of(input int i);
        case (i)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    // observed result packed as {cout, ovf, sum}
    function automatic logic [33:0] obs(input int i);
        case (i)
            0:       return {co0, of0, 16'h0, s0};
            1:       return {co1, of1, 24'h0, s1};
            default: return {co2, of2, s2};
        endcase
    endfunction

    // arithmetic reference: integer add/subtract, then read off carry and signed range overflow
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic c, input logic s);
        longint ua, ub, t, sa, sbv, sr, half, mask;
        logic   cout, ovf;
        ua   = longint'({32'h0, av});
        ub   = longint'({32'h0, bv});
        half = longint'(1) << (w - 1);
        mask = (longint'(1) << w) - 1;
        if (s) t = ua - ub + (longint'(1) << w);
        else   t = ua + ub + longint'(c);
        sa  = (ua >= half) ? ua - 2 * half : ua;
        sbv = (ub >= half) ? ub - 2 * half : ub;
        sr  = s ? sa - sbv : sa + sbv + longint'(c);
        ovf  = (sr >= half) || (sr < -half);
        cout = ((t >> w) & 1) != 0;
        return {cout, ovf, 32'(t & mask)};
    endfunction

    function automatic logic [31:0] rnd_op(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return m;
            1:       return 32'h0;
            2:       return m >> 1;
            3:       return (m >> 1) + 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic clear_sb();
        for (int i = 0; i < NI; i++) begin
            head[i] = 0; tail[i] = 0; infl[i] = 0;
            acc[i] = 0; popped[i] = 0; held_v[i] = 1'b0;
        end
    endtask

    // per-cycle scoreboard step, called after inputs settle and before the next rising edge
    task automatic observe(input int i, input string tag);
        logic [33:0] got;
        got = obs(i);
        check_eq({tag, "_in_ready"}, 64'(rdy_of(i)), 64'(!(infl[i] == NB[i] && !out_ready[i])));
        if (held_v[i]) begin
            check_eq({tag, "_hold_valid"}, 64'(vld_of(i)), 64'd1);
            check_eq({tag, "_hold"}, 64'(got), 64'(held[i]));
        end
        held_v[i] = 1'b0;
        if (vld_of(i)) begin
            if (infl[i] == 0) begin
                check_eq({tag, "_spurious"}, 64'(vld_of(i)), 64'd0);
            end else if (out_ready[i]) begin
                check_eq({tag, "_result"}, 64'(got), 64'(sb[i][head[i]]));
                head[i] = (head[i] + 1) % 16;
                infl[i]--;
                popped[i]++;
            end else begin
                held_v[i] = 1'b1;
                held[i]   = got;
            end
        end
        if (in_valid[i] && rdy_of(i)) begin
            sb[i][tail[i]] = model(WD[i], a[i], b[i], cin[i], sub[i]);
            tail[i] = (tail[i] + 1) % 16;
            infl[i]++;
            acc[i]++;
        end
    endtask

    // one isolated operation on an idle pipeline; checks latency and result
    task automatic single_op(input int i, input logic [31:0] av, input logic [31:0] bv,
                             input logic c, input logic s, input string tag, input logic [33:0] exp);
        @(negedge clk);
        a[i] = av; b[i] = bv; cin[i] = c; sub[i] = s;
        in_valid[i] = 1'b1; out_ready[i] = 1'b1;
        #1;
        check_eq({tag, "_accept"}, 64'(rdy_of(i)), 64'd1);
        @(negedge clk);
        in_valid[i] = 1'b0;
        for (int e = 1; e < NB[i]; e++) begin
            check_eq({tag, "_early"}, 64'(vld_of(i)), 64'd0);
            @(negedge clk);
        end
        check_eq({tag, "_latency"}, 64'(vld_of(i)), 64'd1);
        check_eq({tag, "_value"}, 64'(obs(i)), 64'(exp));
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb;
        logic        rc, rs;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1;
            a[i] = '0; b[i] = '0; cin[i] = 1'b0; sub[i] = 1'b0;
        end
        clear_sb();

        @(negedge clk);
        #1;
        check_eq("reset_out_valid16", 64'(ov0), 64'd0);
        check_eq("reset_out_valid8", 64'(ov1), 64'd0);
        check_eq("reset_out_valid32", 64'(ov2), 64'd0);
        check_eq("reset_result16", 64'(obs(0)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_in_ready", 64'(rdy0), 64'd1);

        single_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, "add_ffff_1", {1'b1, 1'b0, 32'h0000});
        single_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, "add_7fff_1", {1'b0, 1'b1, 32'h8000});
        single_op(0, 32'h8000, 32'h8000, 1'b0, 1'b0, "add_8000_8000", {1'b1, 1'b1, 32'h0000});
        single_op(0, 32'h0005, 32'h0007, 1'b1, 1'b1, "sub_5_7", {1'b0, 1'b0, 32'hFFFE});
        single_op(0, 32'h0007, 32'h0005, 1'b0, 1'b1, "sub_7_5", {1'b1, 1'b0, 32'h0002});
        for (int i = 1; i < NI; i++) begin
            ra = rnd_op(WD[i]); rb = rnd_op(WD[i]);
            rc = 1'($urandom); rs = 1'($urandom);
            single_op(i, ra, rb, rc, rs, "lat_rand", model(WD[i], ra, rb, rc, rs));
        end

        // backpressure: six back-to-back ops, consumer stalled in cycles 4..8
        clear_sb();
        saw_full = 1'b0;
        for (int c = 0; c < 60 && popped[0] < 6; c++) begin
            @(negedge clk);
            out_ready[0] = !(c >= 4 && c <= 8);
            in_valid[0]  = (acc[0] < 6);
            a[0]   = {16'h0, 16'(16'h1357 * (acc[0] + 1))};
            b[0]   = {16'h0, 16'(16'h0F0F + acc[0])};
            sub[0] = (acc[0] % 2) == 1;
            cin[0] = 1'b1;
            #1;
            if (!rdy0) saw_full = 1'b1;
            observe(0, "bp");
        end
        in_valid[0] = 1'b0;
        check_eq("bp_all_out", 64'(popped[0]), 64'd6);
        check_eq("bp_full_seen", 64'(saw_full), 64'd1);

        // reset with three operations in flight and one already presented
        clear_sb();
        cyc = 0;
        while (cyc < 20 && !(ov0 && acc[0] == 3)) begin
            @(negedge clk);
            out_ready[0] = 1'b0;
            in_valid[0]  = (acc[0] < 3);
            a[0] = 32'h1234 + 32'(acc[0]); b[0] = 32'h0101; sub[0] = 1'b0; cin[0] = 1'b0;
            #1;
            observe(0, "rst_fill");
            cyc++;
        end
        check_eq("rst_fill_reached", 64'(ov0), 64'd1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(ov0), 64'd0);
        check_eq("rst_result", 64'(obs(0)), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
        out_ready[0] = 1'b1;
        #1;
        check_eq("rst_release_in_ready", 64'(rdy0), 64'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            check_eq("rst_no_stale", 64'(ov0), 64'd0);
        end

        // random streams with random consumer stalls on all three configurations at once
        clear_sb();
        cyc = 0;
        while (cyc < 60000 && (popped[0] < NOPS || popped[1] < NOPS || popped[2] < NOPS)) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                out_ready[i] = ($urandom_range(0, 3) != 0);
                if (acc[i] < NOPS && $urandom_range(0, 4) != 0) begin
                    in_valid[i] = 1'b1;
                    a[i]   = rnd_op(WD[i]);
                    b[i]   = rnd_op(WD[i]);
                    cin[i] = 1'($urandom);
                    sub[i] = 1'($urandom);
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                observe(i, "rnd");
            end
            cyc++;
        end
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            check_eq("rnd_all_out", 64'(popped[i]), 64'(NOPS));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_skip_adder.md
# pipelined_carry_skip_adder

Parametrised, pipelined carry-skip adder/subtractor: the next generation of the team's 4-bit ripple and carry-skip adders. It splits a WIDTH-bit operation into WIDTH/BLOCK skip blocks, with one pipeline register after each block, and accepts one operation per cycle through a valid/ready handshake with full backpressure. It sits in the adder characterisation datapath between the operand source and the result checker/LED driver.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, skip-block width in bits. NBLK = WIDTH/BLOCK is both the pipeline depth and the latency.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all stage valids immediately.
- in_valid  in  1  operand word present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB; in subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow, equal to the carry into the MSB XOR cout.

## Operation
- Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- At acceptance, B is replaced by B_eff = sub ? ~b : b, and the carry in by c0 = sub ? 1 : cin.
- Skip block k computes bits [k*BLOCK +: BLOCK]:
  - Ripple sum from the incoming carry.
  - Block propagate P = AND of (a_i ^ b_i).
  - Block carry out = P ? carry_in : ripple_cout.
  - The skip mux is a structural requirement, not only a functional one.
- Stage k register holds:
  - the valid bit;
  - sum bits [0 .. (k+1)*BLOCK-1];
  - the remaining upper A and B_eff bits;
  - the block carry out;
  - for the last stage only, the carry into the MSB (needed for ovf).
- Block 0 is computed combinationally from the ports into stage 0. Block k is computed from stage k-1 into stage k.
- Elastic pipeline:
  - stage k advances when it is empty, or when stage k+1 advances (the output is stage NBLK-1, which advances on out_ready).
  - in_ready = !valid[0] || stage 0 advances.
  - The ready chain is combinational.
  - No bubbles are inserted: sustained throughput is 1 operation per cycle when out_ready=1.
- Results leave in acceptance order. Nothing is dropped or duplicated under any out_ready pattern.
- Capacity is NBLK operations in flight.

## Timing
- Reset (asynchronous, immediate):
  - all valid bits = 0, so out_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - in_ready = 1 from the first cycle after deassertion.
- Latency: an operation accepted at edge E appears on out_valid/sum in the cycle after edge E+NBLK-1, i.e. NBLK cycles after it was presented. With NBLK=1 the result is simply registered.
- While out_valid=1 and out_ready=0:
  - sum, cout and ovf hold stable;
  - upstream stages fill their empty slots;
  - in_ready falls once all NBLK stages are valid.
- Simultaneous output pop and input accept when full: allowed in the same cycle; occupancy stays NBLK.
- Reset mid-operation: in-flight operations are discarded; no stale result is ever presented after release.
- Data registers need no reset. Valid bits and the output registers do.
- Parameter error:
  - WIDTH % BLOCK != 0, or BLOCK < 1, is a fatal elaboration error;
  - BLOCK = WIDTH is legal (one stage, no skip).

## Structure
- Package adder_pkg holds:
  - the default WIDTH and BLOCK;
  - the function computing NBLK;
  - the parameter-check macro shared with the other adders.
- One sub-module, skip_block (parameter BLOCK):
  - inputs a, b, cin;
  - outputs sum, cout, prop;
  - purely combinational: a ripple chain plus the skip mux.
- pipelined_carry_skip_adder contains a generate loop over the NBLK skip_block instances and the stage registers/valid chain.

## Test plan
- WIDTH=16, BLOCK=4, add 0xFFFF + 0x0001, cin=0, -> after 4 cycles sum=0x0000, cout=1, ovf=0 (carry crosses all skip paths).
- Add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Add 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x0007 - 0x0005 -> sum=0x0002, cout=1, ovf=0.
- Backpressure:
  - stimulus: 6 back-to-back operations, out_ready held low for cycles 4-8;
  - required: in_ready drops with exactly 4 operations in flight;
  - required: all 6 results emerge in order, sum stable while stalled.
- Reset mid-flight: assert rst with 3 operations in flight -> out_valid=0 and sum=0 immediately, and no result appears in the 8 cycles after release.
- WIDTH=8, BLOCK=8 (1 stage) and WIDTH=32, BLOCK=4 (8 stages):
  - random add/sub stream with random out_ready versus a reference model;
  - required: zero mismatches over 10k operations;
  - required: latency equals NBLK.
